// File: rtl/ff_step_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : ff_step_controller_if
//  Purpose  : Board-side bundle for the flip-flop step controller: raw
//             buttons/switches toward the controller, flop drive signals and
//             step counter back out.
//  Revision : 1.0  initial release
// ============================================================================
interface ff_step_controller_if #(
    parameter int CNT_W = 8
);
    logic             step_noisy;
    logic             mode_noisy;
    logic             auto_noisy;
    logic             din;
    logic             k_in;
    logic             ff_tick;
    logic             ff_clear;
    logic [1:0]       mode;
    logic             d_out;
    logic             j_out;
    logic             k_out;
    logic             t_out;
    logic [CNT_W-1:0] step_count;

    // Board / stimulus side
    modport master (
        output step_noisy, mode_noisy, auto_noisy, din, k_in,
        input  ff_tick, ff_clear, mode, d_out, j_out, k_out, t_out, step_count
    );

    // Controller side
    modport slave (
        input  step_noisy, mode_noisy, auto_noisy, din, k_in,
        output ff_tick, ff_clear, mode, d_out, j_out, k_out, t_out, step_count
    );
endinterface
`default_nettype wire

// File: rtl/ff_step_controller.sv
`default_nettype none
// ============================================================================
//  Module   : ff_step_controller
//  Purpose  : Debounces the step/mode/auto controls, issues single-cycle
//             clock-enable strobes (manual or periodic) to the flop under
//             test, selects its personality (D/JK/T) and routes the data
//             switches to the matching flop inputs.
//  Revision : 1.0  initial release
// ============================================================================
module ff_step_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AUTO_PERIOD     = 50000000,
    parameter int CNT_W           = 8
) (
    input  wire                 Clock50M,
    input  wire                 reset,
    ff_step_controller_if.slave bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AP_W = $clog2(AUTO_PERIOD + 1);
    localparam logic [DB_W-1:0] C_DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [AP_W-1:0] C_AP_LAST = AP_W'(AUTO_PERIOD - 1);

    // Bit positions inside the synchronizer vector
    localparam int C_STEP = 0;
    localparam int C_MODE = 1;
    localparam int C_AUTO = 2;
    localparam int C_DIN  = 3;
    localparam int C_K    = 4;

    localparam logic [1:0] C_MODE_D  = 2'd0;
    localparam logic [1:0] C_MODE_JK = 2'd1;
    localparam logic [1:0] C_MODE_T  = 2'd2;
    localparam logic [1:0] C_MODE_X  = 2'd3;

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_AUTO   = 2'd1,
        ST_CLEAR  = 2'd2
    } state_t;

    logic [4:0]       w_raw;
    logic [4:0]       r_sync1;
    logic [4:0]       r_sync2;
    logic [2:0]       w_db;
    logic [1:0]       r_db_q;
    logic             r_step_rise;
    logic             r_mode_rise;
    logic             w_auto;
    logic [1:0]       w_mode_next;

    state_t           r_state;
    logic [1:0]       r_mode;
    logic [AP_W-1:0]  r_auto_cnt;
    logic [CNT_W-1:0] r_step_count;
    logic             r_tick;
    logic             r_clear;
    logic             r_d;
    logic             r_j;
    logic             r_k;
    logic             r_t;

    assign w_raw = {bus.k_in, bus.din, bus.auto_noisy, bus.mode_noisy, bus.step_noisy};

    // Two-flop synchronizer for every asynchronous board input
    always_ff @(posedge Clock50M or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_debounce
            logic            r_lvl;
            logic [DB_W-1:0] r_cnt;

            // Level only follows the input after it has differed for DEBOUNCE_CYCLES cycles
            always_ff @(posedge Clock50M or posedge reset) begin
                if (reset) begin
                    r_lvl <= 1'b0;
                    r_cnt <= '0;
                end else if (r_sync2[gi] == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == C_DB_LAST) begin
                    r_lvl <= r_sync2[gi];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + DB_W'(1);
                end
            end

            assign w_db[gi] = r_lvl;
        end
    endgenerate

    assign w_auto      = w_db[C_AUTO];
    assign w_mode_next = (r_mode == C_MODE_T) ? C_MODE_D : r_mode + 2'd1;

    // Registered rising-edge pulses of the debounced step and mode buttons
    always_ff @(posedge Clock50M or posedge reset) begin
        if (reset) begin
            r_db_q      <= '0;
            r_step_rise <= 1'b0;
            r_mode_rise <= 1'b0;
        end else begin
            r_db_q      <= w_db[1:0];
            r_step_rise <= w_db[C_STEP] & ~r_db_q[C_STEP];
            r_mode_rise <= w_db[C_MODE] & ~r_db_q[C_MODE];
        end
    end

    // Control FSM: manual/auto stepping, one-cycle clear on mode change; a mode
    // edge always takes priority over a tick in the same cycle
    always_ff @(posedge Clock50M or posedge reset) begin
        if (reset) begin
            r_state      <= ST_MANUAL;
            r_mode       <= C_MODE_D;
            r_auto_cnt   <= '0;
            r_step_count <= '0;
            r_tick       <= 1'b0;
            r_clear      <= 1'b0;
        end else begin
            r_tick  <= 1'b0;
            r_clear <= 1'b0;
            if (r_mode == C_MODE_X) begin
                r_state    <= ST_MANUAL;
                r_mode     <= C_MODE_D;
                r_auto_cnt <= '0;
            end else begin
                case (r_state)
                    ST_MANUAL: begin
                        if (r_mode_rise) begin
                            r_state      <= ST_CLEAR;
                            r_clear      <= 1'b1;
                            r_mode       <= w_mode_next;
                            r_step_count <= '0;
                            r_auto_cnt   <= '0;
                        end else begin
                            if (r_step_rise) begin
                                r_tick       <= 1'b1;
                                r_step_count <= r_step_count + CNT_W'(1);
                            end
                            if (w_auto) begin
                                r_state    <= ST_AUTO;
                                r_auto_cnt <= '0;
                            end
                        end
                    end
                    ST_AUTO: begin
                        if (r_mode_rise) begin
                            r_state      <= ST_CLEAR;
                            r_clear      <= 1'b1;
                            r_mode       <= w_mode_next;
                            r_step_count <= '0;
                            r_auto_cnt   <= '0;
                        end else if (!w_auto) begin
                            r_state    <= ST_MANUAL;
                            r_auto_cnt <= '0;
                        end else if (r_auto_cnt == C_AP_LAST) begin
                            r_tick       <= 1'b1;
                            r_step_count <= r_step_count + CNT_W'(1);
                            r_auto_cnt   <= '0;
                        end else begin
                            r_auto_cnt <= r_auto_cnt + AP_W'(1);
                        end
                    end
                    ST_CLEAR: begin
                        r_state    <= w_auto ? ST_AUTO : ST_MANUAL;
                        r_auto_cnt <= '0;
                    end
                    default: begin
                        r_state    <= ST_MANUAL;
                        r_mode     <= C_MODE_D;
                        r_auto_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Flop data inputs, registered from the synchronized switches; unused ones held at 0
    always_ff @(posedge Clock50M or posedge reset) begin
        if (reset) begin
            r_d <= 1'b0;
            r_j <= 1'b0;
            r_k <= 1'b0;
            r_t <= 1'b0;
        end else begin
            r_d <= (r_mode == C_MODE_D)  & r_sync2[C_DIN];
            r_j <= (r_mode == C_MODE_JK) & r_sync2[C_DIN];
            r_k <= (r_mode == C_MODE_JK) & r_sync2[C_K];
            r_t <= (r_mode == C_MODE_T)  & r_sync2[C_DIN];
        end
    end

    assign bus.ff_tick    = r_tick;
    assign bus.ff_clear   = r_clear;
    assign bus.mode       = r_mode;
    assign bus.d_out      = r_d;
    assign bus.j_out      = r_j;
    assign bus.k_out      = r_k;
    assign bus.t_out      = r_t;
    assign bus.step_count = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_ff_step_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ff_step_controller
//  Purpose  : Self-checking bench for ff_step_controller with short debounce
//             and auto periods; expected step counts are queued as stimulus
//             is applied and popped when each tick appears.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ff_step_controller;
    localparam int DB  = 4;
    localparam int AP  = 10;
    localparam int CW  = 8;
    // Negedges from driving a held input to the first negedge showing the tick:
    // DB+3 rising edges after the sampling edge, sampled half a cycle later.
    localparam int LAT = DB + 4;

    logic          clk = 1'b0;
    logic          rst;
    int            n_checks  = 0;
    int            n_pass    = 0;
    int            n_ticks   = 0;
    int            n_clears  = 0;
    int            n_both    = 0;
    int            n_dbl     = 0;
    logic          prev_tick = 1'b0;
    logic [CW-1:0] model_cnt = '0;
    logic [1:0]    model_mode = 2'd0;
    logic [CW-1:0] exp_q [$];

    ff_step_controller_if #(.CNT_W(CW)) bus ();

    ff_step_controller #(
        .DEBOUNCE_CYCLES (DB),
        .AUTO_PERIOD     (AP),
        .CNT_W           (CW)
    ) dut (
        .Clock50M (clk),
        .reset    (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Event counters for ticks, clears and illegal overlaps
    always @(negedge clk) begin
        if (bus.ff_tick === 1'b1)                   n_ticks  <= n_ticks + 1;
        if (bus.ff_clear === 1'b1)                  n_clears <= n_clears + 1;
        if (bus.ff_tick === 1'b1 && bus.ff_clear === 1'b1) n_both <= n_both + 1;
        if (bus.ff_tick === 1'b1 && prev_tick === 1'b1)    n_dbl  <= n_dbl + 1;
        prev_tick <= bus.ff_tick;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_tick(input int limit, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.ff_tick !== 1'b1 && lat < limit);
        if (bus.ff_tick !== 1'b1) lat = -1;
    endtask

    task automatic push_tick;
        model_cnt = model_cnt + 1'b1;
        exp_q.push_back(model_cnt);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.step_noisy = 1'b0; bus.mode_noisy = 1'b0; bus.auto_noisy = 1'b0;
        bus.din = 1'b0; bus.k_in = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.ff_tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", bus.ff_tick); else n_pass++;
        n_checks++; if (bus.ff_clear !== 1'b0) $display("FAIL reset_clear: got %b want 0", bus.ff_clear); else n_pass++;
        n_checks++; if (bus.mode !== 2'd0) $display("FAIL reset_mode: got %0d want 0", bus.mode); else n_pass++;
        n_checks++; if (bus.step_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", bus.step_count); else n_pass++;
        n_checks++; if ({bus.d_out, bus.j_out, bus.k_out, bus.t_out} !== 4'b0000)
            $display("FAIL reset_data: got %b want 0000", {bus.d_out, bus.j_out, bus.k_out, bus.t_out}); else n_pass++;
        rst = 1'b0;
        model_cnt = '0;
        model_mode = 2'd0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_step_latency;
        int lat, t0;
        logic [CW-1:0] exp;
        #1 t0 = n_ticks;
        push_tick();
        bus.step_noisy = 1'b1;
        wait_tick(30, lat);
        n_checks++; if (lat != LAT) $display("FAIL step_latency: got %0d want %0d", lat, LAT); else n_pass++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_checks++; if (bus.step_count !== exp) $display("FAIL step_count: got %0d want %0d", bus.step_count, exp); else n_pass++;
        repeat (20 - LAT) @(negedge clk);
        bus.step_noisy = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        n_checks++; if (n_ticks - t0 != 1) $display("FAIL step_single: got %0d ticks want 1", n_ticks - t0); else n_pass++;
    endtask

    task automatic test_bounce;
        int lat, t0;
        logic [CW-1:0] exp;
        #1 t0 = n_ticks;
        for (int i = 0; i < 4; i++) begin
            bus.step_noisy = (i % 2 == 0);
            @(negedge clk);
        end
        push_tick();
        bus.step_noisy = 1'b1;
        wait_tick(30, lat);
        n_checks++; if (lat != LAT) $display("FAIL bounce_latency: got %0d want %0d", lat, LAT); else n_pass++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_checks++; if (bus.step_count !== exp) $display("FAIL bounce_count: got %0d want %0d", bus.step_count, exp); else n_pass++;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.step_noisy = (i % 2 == 1);
            @(negedge clk);
        end
        bus.step_noisy = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        n_checks++; if (n_ticks - t0 != 1) $display("FAIL bounce_ticks: got %0d want 1", n_ticks - t0); else n_pass++;
    endtask

    task automatic test_mode;
        int lat, c0;
        logic [CW-1:0] exp;
        logic [3:0] exp_route, got_route;
        bus.din = 1'b1;
        bus.k_in = 1'b1;
        repeat (4) @(negedge clk);
        got_route = {bus.d_out, bus.j_out, bus.k_out, bus.t_out};
        n_checks++; if (got_route !== 4'b1000) $display("FAIL route_d: got %b want 1000", got_route); else n_pass++;
        for (int p = 0; p < 3; p++) begin
            push_tick();
            bus.step_noisy = 1'b1;
            wait_tick(30, lat);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_checks++; if (bus.step_count !== exp) $display("FAIL mode%0d_pre_count: got %0d want %0d", p, bus.step_count, exp); else n_pass++;
            repeat (4) @(negedge clk);
            bus.step_noisy = 1'b0;
            repeat (12) @(negedge clk);
            #1 c0 = n_clears;
            bus.mode_noisy = 1'b1;
            repeat (12) @(negedge clk);
            #1;
            model_mode = (model_mode == 2'd2) ? 2'd0 : model_mode + 2'd1;
            model_cnt = '0;
            exp_route = {(model_mode == 2'd0) & bus.din, (model_mode == 2'd1) & bus.din,
                         (model_mode == 2'd1) & bus.k_in, (model_mode == 2'd2) & bus.din};
            got_route = {bus.d_out, bus.j_out, bus.k_out, bus.t_out};
            n_checks++; if (n_clears - c0 != 1) $display("FAIL mode%0d_clear: got %0d pulses want 1", p, n_clears - c0); else n_pass++;
            n_checks++; if (bus.mode !== model_mode) $display("FAIL mode%0d_mode: got %0d want %0d", p, bus.mode, model_mode); else n_pass++;
            n_checks++; if (bus.step_count !== model_cnt) $display("FAIL mode%0d_count: got %0d want 0", p, bus.step_count); else n_pass++;
            n_checks++; if (got_route !== exp_route) $display("FAIL mode%0d_route: got %b want %b", p, got_route, exp_route); else n_pass++;
            bus.mode_noisy = 1'b0;
            repeat (12) @(negedge clk);
        end
    endtask

    task automatic test_simultaneous;
        int lat, t0, c0;
        logic [CW-1:0] exp;
        push_tick();
        bus.step_noisy = 1'b1;
        wait_tick(30, lat);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_checks++; if (bus.step_count !== exp) $display("FAIL simul_pre_count: got %0d want %0d", bus.step_count, exp); else n_pass++;
        repeat (4) @(negedge clk);
        bus.step_noisy = 1'b0;
        repeat (12) @(negedge clk);
        #1 begin t0 = n_ticks; c0 = n_clears; end
        bus.step_noisy = 1'b1;
        bus.mode_noisy = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        model_mode = (model_mode == 2'd2) ? 2'd0 : model_mode + 2'd1;
        model_cnt = '0;
        n_checks++; if (n_clears - c0 != 1) $display("FAIL simul_clear: got %0d want 1", n_clears - c0); else n_pass++;
        n_checks++; if (n_ticks - t0 != 0) $display("FAIL simul_tick: got %0d want 0", n_ticks - t0); else n_pass++;
        n_checks++; if (bus.mode !== model_mode) $display("FAIL simul_mode: got %0d want %0d", bus.mode, model_mode); else n_pass++;
        n_checks++; if (bus.step_count !== model_cnt) $display("FAIL simul_count: got %0d want 0", bus.step_count); else n_pass++;
        bus.step_noisy = 1'b0;
        bus.mode_noisy = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        n_checks++; if (n_ticks - t0 != 0) $display("FAIL simul_release: got %0d ticks want 0", n_ticks - t0); else n_pass++;
    endtask

    task automatic test_auto;
        int lat, gap, t0;
        logic [CW-1:0] exp;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_cnt = '0;
        model_mode = 2'd0;
        #1 t0 = n_ticks;
        for (int i = 0; i < 5; i++) push_tick();
        bus.auto_noisy = 1'b1;
        wait_tick(40, lat);
        n_checks++; if (lat < 0) $display("FAIL auto_first: got timeout want tick"); else n_pass++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_checks++; if (bus.step_count !== exp) $display("FAIL auto_count1: got %0d want %0d", bus.step_count, exp); else n_pass++;
        for (int k = 2; k <= 5; k++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
                if (k == 2 && gap == 2) bus.step_noisy = 1'b1;
                if (k == 4 && gap == 2) bus.step_noisy = 1'b0;
            end while (bus.ff_tick !== 1'b1 && gap < 3 * AP);
            n_checks++; if (gap != AP) $display("FAIL auto_gap%0d: got %0d want %0d", k, gap, AP); else n_pass++;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_checks++; if (bus.step_count !== exp) $display("FAIL auto_count%0d: got %0d want %0d", k, bus.step_count, exp); else n_pass++;
        end
        bus.auto_noisy = 1'b0;
        repeat (25) @(negedge clk);
        #1;
        n_checks++; if (n_ticks - t0 != 5) $display("FAIL auto_total: got %0d ticks want 5", n_ticks - t0); else n_pass++;
        n_checks++; if (bus.step_count !== 8'd5) $display("FAIL auto_final_count: got %0d want 5", bus.step_count); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL auto_queue: got %0d left want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [CW-1:0] exp;
        bus.mode_noisy = 1'b1;
        repeat (12) @(negedge clk);
        bus.mode_noisy = 1'b0;
        repeat (12) @(negedge clk);
        model_mode = 2'd1;
        model_cnt = '0;
        push_tick();
        push_tick();
        bus.auto_noisy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_tick(40, lat);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_checks++; if (bus.step_count !== exp) $display("FAIL mid_auto_count%0d: got %0d want %0d", i, bus.step_count, exp); else n_pass++;
        end
        repeat (3) @(negedge clk);
        bus.step_noisy = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if ({bus.ff_tick, bus.ff_clear, bus.mode} !== 4'b0000)
            $display("FAIL mid_reset_ctrl: got %b want 0000", {bus.ff_tick, bus.ff_clear, bus.mode}); else n_pass++;
        n_checks++; if (bus.step_count !== 8'd0) $display("FAIL mid_reset_count: got %0d want 0", bus.step_count); else n_pass++;
        n_checks++; if ({bus.d_out, bus.j_out, bus.k_out, bus.t_out} !== 4'b0000)
            $display("FAIL mid_reset_data: got %b want 0000", {bus.d_out, bus.j_out, bus.k_out, bus.t_out}); else n_pass++;
        bus.auto_noisy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_cnt = '0;
        model_mode = 2'd0;
        push_tick();
        wait_tick(30, lat);
        n_checks++; if (lat != LAT) $display("FAIL held_latency: got %0d want %0d", lat, LAT); else n_pass++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_checks++; if (bus.step_count !== exp) $display("FAIL held_count: got %0d want %0d", bus.step_count, exp); else n_pass++;
        bus.step_noisy = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_invariants;
        #1;
        n_checks++; if (n_both != 0) $display("FAIL tick_clear_overlap: got %0d want 0", n_both); else n_pass++;
        n_checks++; if (n_dbl != 0) $display("FAIL tick_back_to_back: got %0d want 0", n_dbl); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_step_latency();
        test_bounce();
        test_mode();
        test_simultaneous();
        test_auto();
        test_reset_mid();
        test_invariants();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ff_step_controller.md
Name: ff_step_controller

Overview:
- Sequences the single flip-flop-under-test (D, JK or T) on the lab board.
- Debounces the raw step and mode buttons and the auto switch, and issues single-cycle clock-enable strobes to the flop (manual or periodic auto-step).
- Selects the flop personality and routes the data switches to the matching d/j/k/t inputs.
- Sits between the board I/O and the flop; the flop samples its inputs only on cycles where ff_tick=1.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a debounced level changes (10 ms at 50 MHz)
AUTO_PERIOD, 50000000, cycles between auto-step ticks (1 s at 50 MHz)
CNT_W, 8, width of step_count

Ports:
Clock50M  input  1  50 MHz system clock; all logic rising-edge
reset  input  1  asynchronous, active-high reset
step_noisy  input  1  raw step pushbutton
mode_noisy  input  1  raw mode pushbutton
auto_noisy  input  1  raw auto-step slide switch
din  input  1  data switch; drives d, j or t depending on mode
k_in  input  1  k switch; used in JK mode only
ff_tick  output  1  one-cycle flop enable strobe
ff_clear  output  1  one-cycle flop clear strobe on mode change
mode  output  2  0=D, 1=JK, 2=T
d_out  output  1  flop d input
j_out  output  1  flop j input
k_out  output  1  flop k input
t_out  output  1  flop t input
step_count  output  CNT_W  ticks issued since the last reset or mode change

Behaviour:
- Reset (async, high): all outputs 0, mode=0 (D); synchronizers, debounced levels, debounce counters and the auto counter all go to 0. Reset is honoured at any point, including mid-debounce and mid-auto-period.
- Input conditioning: each of step_noisy, mode_noisy, auto_noisy, din and k_in passes through a 2-flop synchronizer.
- Debounce (step, mode, auto; one filter each):
  - The counter increments while the synchronized input differs from the debounced level and clears to 0 on any match.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the input still differs, the debounced level takes the new value next cycle and the counter clears.
- Step latency: ff_tick is asserted exactly DEBOUNCE_CYCLES+3 cycles after the first clock edge that samples step_noisy high, provided the input is held stable.
- A button held through reset release produces a tick after full debounce, because the debounced level resets to 0.
- Control FSM states: MANUAL, AUTO, CLEAR.
- MANUAL:
  - A rising edge of debounced step gives ff_tick=1 for one cycle, then the FSM stays in MANUAL.
  - Falling edges and held levels produce nothing.
  - If debounced auto=1, go to AUTO with the auto counter at 0.
- AUTO:
  - The auto counter increments every cycle.
  - At AUTO_PERIOD-1: ff_tick=1 and the counter wraps to 0.
  - Step edges are ignored.
  - If debounced auto=0, go to MANUAL; the counter clears and no tick is issued on exit.
- CLEAR:
  - Entered from MANUAL or AUTO on a rising edge of debounced mode.
  - Lasts exactly one cycle, with ff_clear=1 and ff_tick=0.
  - mode advances 0→1→2→0.
  - step_count clears to 0 and the auto counter clears.
  - Exits to AUTO if debounced auto=1, else MANUAL.
- Simultaneous events: a mode edge and a step edge, or a mode edge and an auto tick, in the same cycle → the mode change wins and that tick is dropped.
- step_count increments by 1 on every ff_tick and wraps from 2^CNT_W-1 to 0.
- Data routing: registered one cycle from the synchronized switches, so data is stable at least one cycle before any tick. Unused outputs are 0.
  - mode 0 (D): d_out=din.
  - mode 1 (JK): j_out=din, k_out=k_in.
  - mode 2 (T): t_out=din.
- Illegal state or mode=3: recover to MANUAL with mode=0 on the next cycle, with no tick and no clear.
- ff_tick and ff_clear are never high in the same cycle. ff_tick is never high on two consecutive cycles.

Test Plan:
- DEBOUNCE_CYCLES=4. Reset, then a clean step press held 20 cycles → exactly one ff_tick, 7 cycles after the first high sample; step_count=1.
- Bounce step_noisy 1,0,1,0 in single cycles, then hold high → no tick during the bounce; one tick after the stable hold; a release with bounce produces no tick.
- Three debounced mode presses → mode goes 1, 2, 0, with ff_clear pulsed once per press and step_count reset to 0 each time. With din=1, k_in=1: check d/j/k/t routing in every mode.
- AUTO_PERIOD=10, auto switch on for 55 cycles after debounce → ff_tick every 10 cycles and step_count=5. Step presses during this window produce no extra ticks.
- Mode and step debounced edges in the same cycle → ff_clear=1, ff_tick=0, mode advanced, step_count=0.
- Assert reset mid-debounce and mid-auto-period → all outputs 0 immediately. With the button still held after release, one tick occurs DEBOUNCE_CYCLES+3 cycles later.
